// File: rtl/norm_2bit_seq.sv
// Iterative mantissa normalizer: shifts out leading zeros two bits per cycle,
// decrementing the biased exponent and stopping at exponent zero (denormal).
module norm_2bit_seq #(
  parameter int MW = 24,
  parameter int EW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MW-1:0]            in_mant,
  input  logic [EW-1:0]            in_exp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MW-1:0]            out_mant,
  output logic [EW-1:0]            out_exp,
  output logic [$clog2(MW+1)-1:0]  out_shift,
  output logic                     out_zero,
  output logic                     out_denorm
);

  localparam int SW = $clog2(MW+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [MW-1:0]   mant_q, mant_d;
  logic [EW-1:0]   exp_q, exp_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic            zero_q, zero_d;
  logic            denorm_q, denorm_d;
  logic [1:0]      top_grp;

  assign top_grp = mant_q[MW-1:MW-2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      shift_q  <= '0;
      zero_q   <= 1'b0;
      denorm_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      shift_q  <= shift_d;
      zero_q   <= zero_d;
      denorm_q <= denorm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    shift_d  = shift_q;
    zero_d   = zero_q;
    denorm_d = denorm_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d   = in_mant;
          exp_d    = in_exp;
          shift_d  = '0;
          denorm_d = 1'b0;
          zero_d   = (in_mant == '0);
          if (in_mant == '0) begin
            exp_d   = '0;
            shift_d = SW'(MW);
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (top_grp[1] || exp_q == '0) begin
          state_d = DONE;
        end else if (top_grp[0] || exp_q == EW'(1)) begin
          // Single-bit step: either one zero left, or the exponent can only afford one
          mant_d  = mant_q << 1;
          exp_d   = exp_q - EW'(1);
          shift_d = shift_q + SW'(1);
          state_d = DONE;
        end else begin
          mant_d  = mant_q << 2;
          exp_d   = exp_q - EW'(2);
          shift_d = shift_q + SW'(2);
        end
        if (state_d == DONE) denorm_d = ~mant_d[MW-1];
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign out_mant   = mant_q;
  assign out_exp    = exp_q;
  assign out_shift  = shift_q;
  assign out_zero   = zero_q;
  assign out_denorm = denorm_q;

endmodule

// File: tb/tb_norm_2bit_seq.sv
// Directed bench for norm_2bit_seq at MW=8, EW=5 with hand-computed results.
module tb_norm_2bit_seq;

  localparam int MW = 8;
  localparam int EW = 5;
  localparam int SW = $clog2(MW+1);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] in_mant;
  logic [EW-1:0] in_exp;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] out_mant;
  logic [EW-1:0] out_exp;
  logic [SW-1:0] out_shift;
  logic          out_zero;
  logic          out_denorm;

  int n_checks = 0;
  int n_pass   = 0;

  norm_2bit_seq #(.MW(MW), .EW(EW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_shift(out_shift),
    .out_zero(out_zero), .out_denorm(out_denorm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, expv);
  endtask

  // Accept one operand, count SHIFT cycles, check the DONE outputs, then retire it.
  task automatic run_op(input logic [MW-1:0] m, input logic [EW-1:0] e, input int ncyc,
                        input logic [MW-1:0] em, input logic [EW-1:0] ee,
                        input logic [SW-1:0] es, input logic ez, input logic ed,
                        input bit hold);
    int cyc;
    @(negedge clk);
    chk("accept_ready", in_ready, 1);
    in_valid  = 1'b1;
    in_mant   = m;
    in_exp    = e;
    out_ready = hold ? 1'b0 : 1'b1;
    @(negedge clk);
    if (hold) in_mant = 8'h01;
    else in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("shift_cycles", cyc, ncyc);
    chk("valid", out_valid, 1);
    chk("busy_ready", in_ready, 0);
    chk("mant", out_mant, em);
    chk("exp", out_exp, ee);
    chk("shift", out_shift, es);
    chk("zero", out_zero, ez);
    chk("denorm", out_denorm, ed);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk("hold_valid", out_valid, 1);
        chk("hold_ready", in_ready, 0);
        chk("hold_mant", out_mant, em);
        chk("hold_exp", out_exp, ee);
        chk("hold_shift", out_shift, es);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(negedge clk);
    chk("retire_valid", out_valid, 0);
    chk("retire_ready", in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mant = '0; in_exp = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_mant", out_mant, 0);
    chk("rst_exp", out_exp, 0);
    chk("rst_shift", out_shift, 0);
    chk("rst_zero", out_zero, 0);
    chk("rst_denorm", out_denorm, 0);
    rst = 1'b0;
    #1;
    chk("rel_ready", in_ready, 1);

    run_op(8'h16, 5'd10, 2, 8'hB0, 5'd7, 4'd3, 1'b0, 1'b0, 1'b0);
    run_op(8'h00, 5'd9,  0, 8'h00, 5'd0, 4'd8, 1'b1, 1'b0, 1'b0);
    run_op(8'h01, 5'd3,  2, 8'h08, 5'd0, 4'd3, 1'b0, 1'b1, 1'b0);
    run_op(8'h80, 5'd5,  1, 8'h80, 5'd5, 4'd0, 1'b0, 1'b0, 1'b0);
    run_op(8'h20, 5'd0,  1, 8'h20, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    run_op(8'h40, 5'd0,  1, 8'h40, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    run_op(8'h01, 5'd20, 4, 8'h80, 5'd13, 4'd7, 1'b0, 1'b0, 1'b0);
    run_op(8'h16, 5'd10, 2, 8'hB0, 5'd7, 4'd3, 1'b0, 1'b0, 1'b1);

    // Abort a long operation mid-SHIFT
    @(negedge clk);
    in_valid = 1'b1; in_mant = 8'h01; in_exp = 5'd20;
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_in_shift", out_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_valid", out_valid, 0);
    chk("abort_ready", in_ready, 0);
    chk("abort_mant", out_mant, 0);
    chk("abort_shift", out_shift, 0);
    rst = 1'b0;
    #1;
    chk("abort_rel_ready", in_ready, 1);
    run_op(8'h40, 5'd4, 1, 8'h80, 5'd3, 4'd1, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
